// File: rtl/sine_scanner_if.sv
// Pixel-side bus of the sine scanner. The scanner is the master: it drives the
// layer address, the palette select and the video outputs.
interface sine_scanner_if;
  logic       scroll_en;
  logic       daynight_sel;
  logic [5:0] layer_rgb;
  logic [5:0] x_out;
  logic [4:0] y_out;
  logic       daynight_out;
  logic [5:0] rgb_out;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       frame_tick;

  modport master (
    input  scroll_en, daynight_sel, layer_rgb,
    output x_out, y_out, daynight_out, rgb_out, hsync, vsync, de, frame_tick
  );

  modport slave (
    output scroll_en, daynight_sel, layer_rgb,
    input  x_out, y_out, daynight_out, rgb_out, hsync, vsync, de, frame_tick
  );
endinterface

// File: rtl/sine_scanner.sv
// VGA-style raster scanner for a horizontally scrolling sine band layer.
// Counters -> stage 1 (layer address) -> stage 2 (pixel and syncs), 2 cycles total.
module sine_scanner #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CELL       = 10,
  parameter int BAND_TOP   = 13,
  parameter int SCROLL_DIV = 1
) (
  input logic            clk,
  input logic            rst,
  sine_scanner_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(CELL + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_ON  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_ON  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] CELL_LAST  = CW'(CELL - 1);
  localparam logic [5:0]    BAND_LO    = 6'(BAND_TOP);
  localparam logic [5:0]    BAND_HI    = 6'(BAND_TOP + 21);
  localparam logic [7:0]    DIV_LAST   = 8'(SCROLL_DIV - 1);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [CW-1:0] hsub, vsub;
  logic [5:0]    col, row;
  logic [5:0]    scroll;
  logic [7:0]    frame_div;
  logic          de_d1, hs_d1, vs_d1;

  logic       h_last, v_last, frame_end, active, hs_n, vs_n, in_band;
  logic [5:0] row_rel;

  assign h_last    = (hcnt == H_LAST);
  assign v_last    = (vcnt == V_LAST);
  assign frame_end = h_last && v_last;
  assign active    = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs_n      = !((hcnt >= H_SYNC_ON) && (hcnt < H_SYNC_OFF));
  assign vs_n      = !((vcnt >= V_SYNC_ON) && (vcnt < V_SYNC_OFF));
  assign in_band   = (row >= BAND_LO) && (row <= BAND_HI);
  assign row_rel   = row - BAND_LO;

  // Frame tick is a pure decode of the counter registers, so it lines up with
  // the undelayed (last pixel, last line) position rather than the video pipe.
  assign bus.frame_tick = frame_end;

  // Cell counters walk alongside hcnt/vcnt so col/row never need a divider.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make update order matter.
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
      hsub <= '0;
      vsub <= '0;
      col  <= '0;
      row  <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      hsub <= '0;
      col  <= '0;
      if (v_last) begin
        vcnt <= '0;
        vsub <= '0;
        row  <= '0;
      end else begin
        vcnt <= vcnt + 1'b1;
        if (vsub == CELL_LAST) begin
          vsub <= '0;
          row  <= row + 1'b1;
        end else begin
          vsub <= vsub + 1'b1;
        end
      end
    end else begin
      hcnt <= hcnt + 1'b1;
      if (hsub == CELL_LAST) begin
        hsub <= '0;
        col  <= col + 1'b1;
      end else begin
        hsub <= hsub + 1'b1;
      end
    end
  end

  // Scroll and palette only move at frame end, so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll           <= '0;
      frame_div        <= '0;
      bus.daynight_out <= 1'b0;
    end else if (frame_end) begin
      bus.daynight_out <= bus.daynight_sel;
      if (bus.scroll_en) begin
        if (frame_div == DIV_LAST) begin
          frame_div <= '0;
          scroll    <= scroll + 1'b1;
        end else begin
          frame_div <= frame_div + 1'b1;
        end
      end
    end
  end

  // Stage 1 presents the layer address; stage 2 captures the layer colour
  // returned for it, together with the syncs delayed to the same pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.x_out   <= '0;
      bus.y_out   <= 5'd31;
      de_d1       <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      bus.rgb_out <= '0;
      bus.de      <= 1'b0;
      bus.hsync   <= 1'b1;
      bus.vsync   <= 1'b1;
    end else begin
      de_d1 <= active;
      hs_d1 <= hs_n;
      vs_d1 <= vs_n;
      if (active) begin
        bus.x_out <= col + scroll;
        bus.y_out <= in_band ? row_rel[4:0] : 5'd31;
      end else begin
        bus.x_out <= '0;
        bus.y_out <= 5'd31;
      end
      bus.rgb_out <= de_d1 ? bus.layer_rgb : 6'd0;
      bus.de      <= de_d1;
      bus.hsync   <= hs_d1;
      bus.vsync   <= vs_d1;
    end
  end
endmodule

// File: doc/sine_scanner.md
SINE_SCANNER -- requirements
Module: sine_scanner

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 visible px/line; H_FP 16; H_SYNC 96; H_BP 48; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; CELL 10 px/lines per layer cell; BAND_TOP 13 first cell row of sine band; SCROLL_DIV 1 frames per scroll step.
REQ-002 Ports (name direction width meaning): clk in 1 pixel clock; rst in 1 asynchronous active-high reset; scroll_en in 1 enable horizontal scroll; daynight_sel in 1 requested palette; layer_rgb in 6 colour returned combinationally by sine layer for current x_out/y_out; x_out out 6 layer column; y_out out 5 layer row; daynight_out out 1 palette to sine layer; rgb_out out 6 RRGGBB pixel; hsync out 1 active low; vsync out 1 active low; de out 1 data enable; frame_tick out 1 one-cycle pulse at frame end.
REQ-003 One clock (clk); reset rst is asynchronous and active-high.

Function
REQ-004 hcnt SHALL count 0..H_total-1 (800), wrapping to 0; vcnt SHALL increment on hcnt wrap, 0..V_total-1 (525), wrapping to 0.
REQ-005 Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE; sync low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), likewise vertical.
REQ-006 Cell counters: hsub 0..CELL-1 and col 0..63 SHALL reset to 0 at hcnt==0 and advance col when hsub wraps; vsub/row SHALL do likewise on line wrap, reset at vcnt==0; no division logic.
REQ-007 Stage 1 (registered, 1 cycle after counters): in active region x_out=(col+scroll)[5:0] (mod-64 wrap), y_out=row-BAND_TOP when BAND_TOP<=row<=BAND_TOP+21 else 5'd31; outside active region x_out=0, y_out=31.
REQ-008 Stage 2 (registered, 1 cycle after stage 1): rgb_out=layer_rgb when de_d1 else 6'b0; hsync, vsync, de SHALL be delayed 2 cycles from counter decode so all four align.
REQ-009 Total latency counter->rgb_out SHALL be exactly 2 clk cycles; layer_rgb SHALL be sampled in the same cycle x_out/y_out are presented.
REQ-010 frame_tick SHALL pulse high for one cycle on the cycle counters are (799,524) (undelayed).
REQ-011 Scroll: on frame_tick with scroll_en=1, frame_div increments; when frame_div==SCROLL_DIV-1 it clears and scroll=(scroll+1) mod 64; scroll_en=0 holds frame_div and scroll.
REQ-012 scroll SHALL change only on frame_tick; no mid-frame tear.
REQ-013 daynight_out SHALL load daynight_sel only on frame_tick; toggling daynight_sel mid-frame SHALL have no effect until next frame end.
REQ-014 scroll 63->0 wrap SHALL be seamless: x_out uses 6-bit modular sum, no carry-out retained.
REQ-015 SCROLL_DIV=1 SHALL step scroll every enabled frame; SCROLL_DIV values 1..255 supported (8-bit frame_div).

Reset
REQ-016 While rst=1: hcnt, vcnt, hsub, vsub, col, row, scroll, frame_div=0; x_out=0; y_out=31; rgb_out=0; hsync=1; vsync=1; de=0; frame_tick=0; daynight_out=0.
REQ-017 rst asserted mid-frame SHALL clear everything immediately (asynchronous); first cycle after release restarts at counter (0,0), first valid rgb_out 2 cycles later.

Verification
REQ-018 Release reset, run 1 frame -> hsync low exactly 96 cycles/line starting at delayed hcnt 656; vsync low exactly 2 lines; de high 640x480 cycles; frame_tick once per 420000 cycles.
REQ-019 scroll=0, counters at pixel (hcnt=25,vcnt=135) -> next cycle x_out=2, y_out=0; pixel (0,0) -> y_out=31; layer_rgb forced 6'h2A -> rgb_out=6'h2A exactly 2 cycles later when de high, 0 in blanking.
REQ-020 scroll_en=1, SCROLL_DIV=1, 64 frames -> scroll steps 0..63 then 0; at scroll=63, col=1 -> x_out=0.
REQ-021 SCROLL_DIV=3, scroll_en=1 for 6 frames then 0 for 3 -> scroll=2, unchanged after disable.
REQ-022 daynight_sel toggled at line 200 -> daynight_out unchanged until frame_tick, updates on following cycle.
REQ-023 rst pulsed at (hcnt=300,vcnt=300) for 1 cycle -> all outputs at reset values asynchronously; scroll=0, timing restarts at (0,0).
